// File: rtl/processador_pkg.sv
// Shared types and constants for the 8-bit processor pipeline.
package processador_pkg;

  localparam int unsigned INSTR_W  = 8;
  localparam int unsigned PC_W     = 8;
  localparam int unsigned OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_HALT = 3'b111;

  // Fetch stage control states.
  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StValid,
    StHalt
  } fetch_state_e;

endpackage

// File: rtl/contador_programa.sv
// Program counter register: asynchronous reset, load and wrapping increment.
module contador_programa
  import processador_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;

  // Load has priority over increment; the increment wraps naturally at 8'hFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= load_val;
    end else if (inc) begin
      pc_q <= pc_q + 8'd1;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch stage: PC ownership, req/ack fetch, instruction register,
// branch redirect with drain of in-flight requests, and halt.
module unidade_busca
  import processador_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC   = 8'h00,
  parameter logic [INSTR_W-1:0] HALT_INSTR = {OP_HALT, 5'b00000}
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                mem_req,
  output logic [PC_W-1:0]     mem_addr,
  input  logic                mem_ack,
  input  logic [INSTR_W-1:0]  mem_rdata,
  input  logic                branch_en,
  input  logic [PC_W-1:0]     branch_target,
  input  logic                dec_ready,
  output logic                instr_valid,
  output logic [INSTR_W-1:0]  instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [1:0]          reg_sel,
  output logic [2:0]          imm3,
  output logic [PC_W-1:0]     pc,
  output logic                halted
);

  fetch_state_e       state_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pending_q;
  logic               mem_req_q;
  logic               instr_valid_q;
  logic               halted_q;

  logic               pc_load;
  logic               pc_inc;
  logic [PC_W-1:0]    pc_load_val;
  logic [PC_W-1:0]    pc_cur;

  contador_programa #(
    .RESET_PC (RESET_PC)
  ) u_contador_programa (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc_cur)
  );

  // PC update control; a branch during an outstanding request only moves the
  // PC once the request has been acknowledged, so mem_addr stays stable.
  always_comb begin
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load_val = branch_target;
    unique case (state_q)
      StIdle, StValid, StHalt: begin
        pc_load = branch_en;
      end
      StFetch: begin
        if (mem_ack && branch_en) begin
          pc_load = 1'b1;
        end else if (mem_ack) begin
          pc_inc = 1'b1;
        end
      end
      StDrain: begin
        if (mem_ack) begin
          pc_load = 1'b1;
          // A branch arriving with the ack is the most recent one.
          pc_load_val = branch_en ? branch_target : pending_q;
        end
      end
      default: ;
    endcase
  end

  // Fetch FSM with instruction/pending registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      instr_q       <= '0;
      pending_q     <= '0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q   <= StFetch;
          mem_req_q <= 1'b1;
        end
        StFetch: begin
          if (branch_en && !mem_ack) begin
            pending_q <= branch_target;
            state_q   <= StDrain;
          end else if (mem_ack && !branch_en) begin
            instr_q       <= mem_rdata;
            state_q       <= StValid;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b1;
          end
          // Branch with ack: data dropped, stay in StFetch at the new PC.
        end
        StDrain: begin
          if (mem_ack) begin
            state_q <= StFetch;
          end else if (branch_en) begin
            pending_q <= branch_target;
          end
        end
        StValid: begin
          if (branch_en) begin
            state_q       <= StFetch;
            instr_valid_q <= 1'b0;
            mem_req_q     <= 1'b1;
          end else if (dec_ready) begin
            instr_valid_q <= 1'b0;
            if (instr_q == HALT_INSTR) begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end else begin
              state_q   <= StFetch;
              mem_req_q <= 1'b1;
            end
          end
        end
        StHalt: begin
          if (branch_en) begin
            state_q   <= StFetch;
            halted_q  <= 1'b0;
            mem_req_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= StIdle;
          mem_req_q     <= 1'b0;
          instr_valid_q <= 1'b0;
          halted_q      <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_cur;
  assign pc          = pc_cur;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[7:5];
  assign reg_sel     = instr_q[4:3];
  assign imm3        = instr_q[2:0];
  assign halted      = halted_q;

endmodule

// File: tb/tb_unidade_busca.sv
// Directed self-checking bench for the fetch stage.
module tb_unidade_busca;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       branch_en;
  logic [7:0] branch_target;
  logic       dec_ready;
  logic       instr_valid;
  logic [7:0] instr;
  logic [2:0] opcode;
  logic [1:0] reg_sel;
  logic [2:0] imm3;
  logic [7:0] pc;
  logic       halted;

  int n_cmp = 0;
  int n_err = 0;

  unidade_busca #(
    .RESET_PC   (8'h00),
    .HALT_INSTR (8'hE0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .dec_ready     (dec_ready),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .opcode        (opcode),
    .reg_sel       (reg_sel),
    .imm3          (imm3),
    .pc            (pc),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00; branch_en = 1'b0;
    branch_target = 8'h00; dec_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({mem_req, mem_addr, instr_valid, instr, opcode, reg_sel, imm3, pc, halted} !==
        {1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 2'd0, 3'd0, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: req=%b addr=%h v=%b instr=%h pc=%h halt=%b, required all zero",
               mem_req, mem_addr, instr_valid, instr, pc, halted);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    tick();  // IDLE -> FETCH
    n_cmp++;
    if ({mem_req, mem_addr, instr_valid} !== {1'b1, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL first_req: req=%b addr=%h v=%b, required 1 00 0", mem_req, mem_addr,
               instr_valid);
    end
    mem_ack = 1'b1; mem_rdata = 8'h2D; dec_ready = 1'b1;
    tick();  // FETCH -> VALID
    n_cmp++;
    if ({instr_valid, instr, opcode, reg_sel, imm3, pc, mem_req} !==
        {1'b1, 8'h2D, 3'b001, 2'b01, 3'b101, 8'h01, 1'b0}) begin
      n_err++;
      $display("FAIL first_valid: v=%b instr=%h op=%b rs=%b imm=%b pc=%h req=%b, required 1 2d 001 01 101 01 0",
               instr_valid, instr, opcode, reg_sel, imm3, pc, mem_req);
    end
    mem_ack = 1'b0;
    tick();  // VALID -> FETCH at 01
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({mem_req, mem_addr, instr_valid} !== {1'b1, 8'h01, 1'b0}) begin
        n_err++;
        $display("FAIL wait_hold[%0d]: req=%b addr=%h v=%b, required 1 01 0", i, mem_req,
                 mem_addr, instr_valid);
      end
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 8'h4A; dec_ready = 1'b0;
    tick();
    n_cmp++;
    if ({instr_valid, instr, pc} !== {1'b1, 8'h4A, 8'h02}) begin
      n_err++;
      $display("FAIL wait_done: v=%b instr=%h pc=%h, required 1 4a 02", instr_valid, instr, pc);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({instr_valid, instr, mem_req, pc} !== {1'b1, 8'h4A, 1'b0, 8'h02}) begin
        n_err++;
        $display("FAIL stall[%0d]: v=%b instr=%h req=%b pc=%h, required 1 4a 0 02", i,
                 instr_valid, instr, mem_req, pc);
      end
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    n_cmp++;
    if ({mem_req, mem_addr, instr_valid} !== {1'b1, 8'h02, 1'b0}) begin
      n_err++;
      $display("FAIL stall_release: req=%b addr=%h v=%b, required 1 02 0", mem_req, mem_addr,
               instr_valid);
    end
  endtask

  task automatic test_branch_drain();
    branch_en = 1'b1; branch_target = 8'h40;
    tick();  // FETCH -> DRAIN
    branch_en = 1'b0;
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h02}) begin
      n_err++;
      $display("FAIL drain_hold0: req=%b addr=%h, required 1 02", mem_req, mem_addr);
    end
    tick();
    n_cmp++;
    if ({mem_req, mem_addr, instr_valid} !== {1'b1, 8'h02, 1'b0}) begin
      n_err++;
      $display("FAIL drain_hold1: req=%b addr=%h v=%b, required 1 02 0", mem_req, mem_addr,
               instr_valid);
    end
    mem_ack = 1'b1; mem_rdata = 8'h99;
    tick();  // DRAIN -> FETCH at 40
    mem_ack = 1'b0;
    n_cmp++;
    if ({mem_req, mem_addr, instr_valid, instr} !== {1'b1, 8'h40, 1'b0, 8'h4A}) begin
      n_err++;
      $display("FAIL drain_redirect: req=%b addr=%h v=%b instr=%h, required 1 40 0 4a", mem_req,
               mem_addr, instr_valid, instr);
    end
    // Two branches while draining: the second wins.
    branch_en = 1'b1; branch_target = 8'h50;
    tick();
    branch_target = 8'h60;
    tick();
    branch_en = 1'b0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_cmp++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h60}) begin
      n_err++;
      $display("FAIL drain_last_wins: req=%b addr=%h, required 1 60", mem_req, mem_addr);
    end
    // Branch together with ack in FETCH: data dropped, refetch at target.
    branch_en = 1'b1; branch_target = 8'h70; mem_ack = 1'b1; mem_rdata = 8'h33;
    tick();
    branch_en = 1'b0; mem_rdata = 8'h2D;
    n_cmp++;
    if ({mem_req, mem_addr, instr_valid, instr} !== {1'b1, 8'h70, 1'b0, 8'h4A}) begin
      n_err++;
      $display("FAIL fetch_ack_branch: req=%b addr=%h v=%b instr=%h, required 1 70 0 4a",
               mem_req, mem_addr, instr_valid, instr);
    end
    tick();  // FETCH -> VALID with 2D
    mem_ack = 1'b0;
    // Branch in VALID drops the instruction even with dec_ready high.
    branch_en = 1'b1; branch_target = 8'h20; dec_ready = 1'b1;
    tick();
    branch_en = 1'b0; dec_ready = 1'b0;
    n_cmp++;
    if ({mem_req, mem_addr, instr_valid, halted} !== {1'b1, 8'h20, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL valid_branch: req=%b addr=%h v=%b halt=%b, required 1 20 0 0", mem_req,
               mem_addr, instr_valid, halted);
    end
  endtask

  task automatic test_wrap_halt();
    branch_en = 1'b1; branch_target = 8'hFF; mem_ack = 1'b1; mem_rdata = 8'h11;
    tick();  // redirect to FF
    branch_en = 1'b0; mem_rdata = 8'hE0; dec_ready = 1'b1;
    tick();  // fetch E0 at FF
    mem_ack = 1'b0;
    n_cmp++;
    if ({instr_valid, instr, opcode, pc} !== {1'b1, 8'hE0, 3'b111, 8'h00}) begin
      n_err++;
      $display("FAIL pc_wrap: v=%b instr=%h op=%b pc=%h, required 1 e0 111 00", instr_valid,
               instr, opcode, pc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({halted, mem_req, instr_valid} !== {1'b1, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL halt[%0d]: halt=%b req=%b v=%b, required 1 0 0", i, halted, mem_req,
                 instr_valid);
      end
    end
    branch_en = 1'b1; branch_target = 8'h10; dec_ready = 1'b0;
    tick();
    branch_en = 1'b0;
    n_cmp++;
    if ({halted, mem_req, mem_addr} !== {1'b0, 1'b1, 8'h10}) begin
      n_err++;
      $display("FAIL halt_exit: halt=%b req=%b addr=%h, required 0 1 10", halted, mem_req,
               mem_addr);
    end
  endtask

  task automatic test_reset_midfetch();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, mem_addr, instr_valid, instr, pc, halted} !==
        {1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: req=%b addr=%h v=%b instr=%h pc=%h halt=%b, required 0 00 0 00 00 0",
               mem_req, mem_addr, instr_valid, instr, pc, halted);
    end
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    tick();
    n_cmp++;
    if ({mem_req, instr, instr_valid} !== {1'b0, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL late_ack_in_reset: req=%b instr=%h v=%b, required 0 00 0", mem_req, instr,
               instr_valid);
    end
    rst_n = 1'b1;
    tick();  // IDLE ignores the ack
    n_cmp++;
    if ({mem_req, mem_addr, instr, instr_valid} !== {1'b1, 8'h00, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL late_ack_idle: req=%b addr=%h instr=%h v=%b, required 1 00 00 0", mem_req,
               mem_addr, instr, instr_valid);
    end
    tick();
    mem_ack = 1'b0;
    n_cmp++;
    if ({instr_valid, instr, pc} !== {1'b1, 8'h5A, 8'h01}) begin
      n_err++;
      $display("FAIL refetch_after_reset: v=%b instr=%h pc=%h, required 1 5a 01", instr_valid,
               instr, pc);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_wait_states();
    test_stall();
    test_branch_drain();
    test_wrap_halt();
    test_reset_midfetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
